ddr_responder_model: RTL
========================

Name: ddr_responder_model

Overview:
Synthesizable responder for the UberDDR3 memrequest interface. It accepts the commands issued by traffic_generator and answers them in order after a fixed latency, using a BRAM-backed store. It models controller init, periodic refresh stalls and a limit on outstanding commands. This lets the frame-buffer path (traffic_generator, command FIFO, read AXIS) be simulated, and run on-chip without the DDR3 PHY.

Parameters:
DEPTH, 131072, number of 128-bit words stored; valid addresses are 0..DEPTH-1
LATENCY, 8, cycles from command acceptance to its complete pulse; must be >= 1
MAX_OUTSTANDING, 6, accepted-but-not-completed commands at which busy asserts; range 1..LATENCY
INIT_CYCLES, 64, cycles busy is held after reset release
REFRESH_PERIOD, 1024, cycles between refresh windows, counted in RUN
REFRESH_CYCLES, 32, length of each refresh window

Ports:
clk  in  1  system clock (DDR ui clock domain)
rst  in  1  synchronous, active-high reset
memrequest_addr  in  24  word address of the command
memrequest_en  in  1  command request; accepted when en && !busy
memrequest_write_data  in  128  write payload
memrequest_write_enable  in  1  1 = write, 0 = read
memrequest_resp_data  out  128  read data; valid only while complete is high for a read
memrequest_complete  out  1  one-cycle pulse per accepted command, reads and writes alike
memrequest_busy  out  1  registered stall; never depends combinationally on en
init_done  out  1  high once INIT has finished
addr_error  out  1  sticky flag: a command was accepted with addr >= DEPTH
outstanding  out  8  accepted commands not yet completed

Behaviour:
- Reset values: busy=1, complete=0, resp_data=0, init_done=0, addr_error=0, outstanding=0, state=INIT. The pipeline is flushed, so in-flight commands never complete. Store contents are not reset.
- Accept: en && !busy at a rising edge. Only one command per cycle.
- Write, addr < DEPTH: mem[addr] <= write_data on the accepting edge.
- Read, addr < DEPTH: mem[addr] is captured on the accepting edge. A read accepted after a write to the same address returns the new data. Commands are strictly in order.
- addr >= DEPTH: addr_error <= 1. A write is dropped; a read returns 0. The command still completes normally.
- Pipeline: an entry {valid, we, rdata} shifts once per cycle. A command accepted at edge t drives complete=1 in the cycle following edge t+LATENCY-1. Complete is registered, so it becomes visible exactly LATENCY cycles after acceptance.
- Response data: for reads, resp_data carries the captured data. For writes, resp_data=0. Whenever complete=0, resp_data=0.
- Outstanding counter:
  - outstanding_next = outstanding + accept - complete_next.
  - Simultaneous accept and complete leaves the count unchanged.
- States (registered enum):
  - INIT: count INIT_CYCLES, then go to RUN and set init_done=1 permanently (until reset).
  - RUN: refresh counter increments; at REFRESH_PERIOD-1 go to REFRESH and clear the counter.
  - REFRESH: count REFRESH_CYCLES, then return to RUN. The pipeline keeps draining, so completes still occur.
- busy register:
  - busy_next = (state_next != RUN) || (outstanding_next >= MAX_OUTSTANDING).
  - busy therefore deasserts on the same edge that the state enters RUN, or that a completion frees a slot.
- A command presented while busy=1 is ignored entirely, with no side effects.
- Reset mid-operation: everything returns to the reset values on the next edge and INIT restarts.
- Widths: addresses are compared in 24 bits. The store index uses $clog2(DEPTH) bits. outstanding saturates logically at LATENCY, which fits in 8 bits.

Decomposition:
- Package ddr_model_pkg:
  - typedef enum {INIT, RUN, REFRESH} ddr_model_state;
  - localparams ADDR_W=24 and DATA_W=128.
- Sub-module resp_pipe, parameterized by LATENCY and WIDTH:
  - a valid/we/data shift register with a synchronous flush;
  - instantiated once.
- The store is an inferred single-port-write / sync-read array in the top module.

Test Plan:
- Init: release rst, hold en=1 → busy=1 for 64 cycles, init_done rises with busy falling, nothing is accepted during INIT, and the first accept happens on the first cycle with busy=0.
- Write/read: write addr 5 = 128'hA5A5…, then read addr 5 on the next cycle → two completes at acceptance+8. The write complete has resp_data=0; the read complete has 128'hA5A5….
- Back-to-back reads with en held: outstanding climbs to 6, then busy=1. Accepts continue at one per completion; 100 reads produce 100 in-order completes, and data matches a scoreboard.
- Refresh: continuous traffic → after 1024 RUN cycles, busy=1 for 32 cycles. Completes from commands already in flight still appear during the window; no accepts occur.
- Out of range: write addr 131072, then read it → addr_error=1 stays set, the read returns 0, addr 0 is unchanged, and both commands complete.
- Reset mid-flight: assert rst with 5 commands outstanding → no completes afterwards, outstanding=0, busy=1, and INIT restarts.

Source files
------------

// File: rtl/ddr_responder_model_pkg.sv
// Shared types and widths for the DDR responder model.
// The state enum is also exported so the FSM can be observed from outside.
package ddr_model_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    REFRESH = 2'd2
  } ddr_model_state;
endpackage

// File: rtl/ddr_responder_model_if.sv
// memrequest bus between a traffic source (master) and the responder (slave).
// Handshake: a command transfers on a rising edge where memrequest_en && !memrequest_busy; busy is a register and never looks at en.
interface ddr_responder_model_if;
  import ddr_model_pkg::*;

  logic [ADDR_W-1:0] memrequest_addr;
  logic              memrequest_en;
  logic [DATA_W-1:0] memrequest_write_data;
  logic              memrequest_write_enable;
  logic [DATA_W-1:0] memrequest_resp_data;
  logic              memrequest_complete;
  logic              memrequest_busy;

  modport master (
    output memrequest_addr, memrequest_en, memrequest_write_data, memrequest_write_enable,
    input  memrequest_resp_data, memrequest_complete, memrequest_busy
  );

  modport slave (
    input  memrequest_addr, memrequest_en, memrequest_write_data, memrequest_write_enable,
    output memrequest_resp_data, memrequest_complete, memrequest_busy
  );
endinterface

// File: rtl/ddr_responder_model_resp_pipe.sv
// Fixed-latency response pipeline carrying {valid, we, data} with a synchronous flush.
// in_data belongs to the entry held in stage 0, so it arrives one cycle after in_valid/in_we.
module resp_pipe #(
  parameter int LATENCY = 8,
  parameter int WIDTH   = 128
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_we,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_we,
  output logic [WIDTH-1:0] out_data,
  output logic             next_valid
);
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] we_q, we_d;

  always_comb begin
    valid_d = LATENCY'({valid_q, in_valid});
    we_d    = LATENCY'({we_q, in_we});
    if (flush) begin
      valid_d = '0;
      we_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    we_q    <= we_d;
  end

  assign out_valid  = valid_q[LATENCY-1];
  assign out_we     = we_q[LATENCY-1];
  assign next_valid = valid_d[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_direct
      assign out_data = in_data;
    end else begin : g_shift
      logic [WIDTH-1:0] data_q [LATENCY-1];
      logic [WIDTH-1:0] data_d [LATENCY-1];

      always_comb begin
        data_d[0] = flush ? '0 : in_data;
        for (int k = 1; k < LATENCY - 1; k++) begin
          data_d[k] = flush ? '0 : data_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        data_q <= data_d;
      end

      assign out_data = data_q[LATENCY-2];
    end
  endgenerate
endmodule

// File: rtl/ddr_responder_model.sv
// BRAM-backed stand-in for the UberDDR3 memrequest port: in-order completes after LATENCY cycles,
// with init hold-off, periodic refresh stalls and an outstanding-command limit.
module ddr_responder_model
  import ddr_model_pkg::*;
#(
  parameter int DEPTH           = 131072,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 6,
  parameter int INIT_CYCLES     = 64,
  parameter int REFRESH_PERIOD  = 1024,
  parameter int REFRESH_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ddr_responder_model_if.slave  mem,
  output logic                  init_done,
  output logic                  addr_error,
  output logic [7:0]            outstanding,
  output ddr_model_state        state
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ddr_model_state    state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              addr_error_q, addr_error_d;
  logic              rd_ok_q, rd_ok_d;
  logic [7:0]        outstanding_q, outstanding_d;

  logic              accept;
  logic              in_range;
  logic              complete_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] store [DEPTH];
  logic [DATA_W-1:0] store_rd_q;
  logic              pipe_valid;
  logic              pipe_we;
  logic [DATA_W-1:0] pipe_data;

  assign accept   = mem.memrequest_en && !busy_q && !rst;
  assign in_range = {8'd0, mem.memrequest_addr} < 32'(DEPTH);
  assign idx      = mem.memrequest_addr[IDX_W-1:0];

  // Store is never reset; out-of-range commands leave it untouched.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      if (mem.memrequest_write_enable) begin
        store[idx] <= mem.memrequest_write_data;
      end else begin
        store_rd_q <= store[idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        if (cnt_q == 32'(INIT_CYCLES - 1)) begin
          state_d     = RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == 32'(REFRESH_PERIOD - 1)) begin
          state_d = REFRESH;
          cnt_d   = '0;
        end
      end
      REFRESH: begin
        if (cnt_q == 32'(REFRESH_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // busy looks ahead at next state and next count so a freed slot or RUN entry unblocks on the same edge.
  always_comb begin
    outstanding_d = outstanding_q + 8'(accept) - 8'(complete_next);
    busy_d        = (state_d != RUN) || (outstanding_d >= 8'(MAX_OUTSTANDING));
    addr_error_d  = addr_error_q || (accept && !in_range);
    rd_ok_d       = accept && in_range && !mem.memrequest_write_enable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
      addr_error_q  <= 1'b0;
      rd_ok_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      addr_error_q  <= addr_error_d;
      rd_ok_q       <= rd_ok_d;
      outstanding_q <= outstanding_d;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (DATA_W)
  ) u_resp_pipe (
    .clk        (clk),
    .flush      (rst),
    .in_valid   (accept),
    .in_we      (accept && mem.memrequest_write_enable),
    .in_data    (rd_ok_q ? store_rd_q : '0),
    .out_valid  (pipe_valid),
    .out_we     (pipe_we),
    .out_data   (pipe_data),
    .next_valid (complete_next)
  );

  assign mem.memrequest_complete  = pipe_valid;
  assign mem.memrequest_resp_data = (pipe_valid && !pipe_we) ? pipe_data : '0;
  assign mem.memrequest_busy      = busy_q;
  assign init_done                = init_done_q;
  assign addr_error               = addr_error_q;
  assign outstanding              = outstanding_q;
  assign state                    = state_q;
endmodule
